rs_cdb_wakeup: RTL and testbench

//  Reservation station that sits on the consumer end of the CDB. It holds dispatched
//  ops and snoops every CDB broadcast port. On a tag match it captures the broadcast

---
 rtl/core_pkg.sv | 26 ++
 rtl/rs_age_matrix.sv | 54 +++++
 rtl/rs_cdb_wakeup.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_rs_cdb_wakeup.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths, the reservation-station default
// size and the station entry record used by rs_cdb_wakeup.
package core_pkg;

  localparam int XLEN               = 32;
  localparam int LOG2_PREGS         = 6;
  localparam int RS_ENTRIES_DEFAULT = 8;
  localparam int RS_ROB_W           = 6;
  localparam int RS_OP_W            = 6;

  // One reservation-station slot. Field widths follow the core-wide constants,
  // so a station instantiated with other widths must keep them in step.
  typedef struct packed {
    logic                  valid;
    logic [RS_OP_W-1:0]    op;
    logic [RS_ROB_W-1:0]   rob_tag;
    logic [LOG2_PREGS-1:0] dst_tag;
    logic [LOG2_PREGS-1:0] src1_tag;
    logic                  src1_ready;
    logic [XLEN-1:0]       src1_value;
    logic [LOG2_PREGS-1:0] src2_tag;
    logic                  src2_ready;
    logic [XLEN-1:0]       src2_value;
  } rs_entry_t;

endpackage

// File: rtl/rs_age_matrix.sv
// Age matrix for the reservation station. older_q[i][j] = 1 means entry i
// was dispatched before entry j. A newly allocated entry is younger than every
// other entry; the grant picks the requester that no other requester is older than.
module rs_age_matrix #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic [N-1:0] alloc_i,
  input  logic [N-1:0] free_i,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);

  logic [N-1:0][N-1:0] older_q;
  logic [N-1:0][N-1:0] older_d;

  // Next ages: new entry's row clears (older than nobody), every other row
  // marks itself older than the newcomer; freed entries drop out of all rows.
  always_comb begin
    older_d = older_q;
    for (int i = 0; i < N; i++) begin
      if (alloc_i[i] || free_i[i]) begin
        older_d[i] = '0;
      end else begin
        older_d[i] = (older_q[i] | alloc_i) & ~free_i;
      end
    end
  end

  // Age state register; flush forgets every ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      older_q <= '0;
    end else if (flush) begin
      older_q <= '0;
    end else begin
      older_q <= older_d;
    end
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi < N; gi++) begin : g_gnt
      logic [N-1:0] older_than_me;
      for (gj = 0; gj < N; gj++) begin : g_col
        assign older_than_me[gj] = older_q[gj][gi];
      end
      assign gnt_o[gi] = req_i[gi] & ~|(req_i & older_than_me);
    end
  endgenerate

endmodule

// File: rtl/rs_cdb_wakeup.sv
// Reservation station on the consumer side of the CDB: holds dispatched ops,
// captures CDB results for waiting sources (including same-cycle dispatch
// bypass) and issues the oldest fully-ready op through a one-deep issue
// register with a valid/ready handshake.
// Optional build macro RS_PERF_CNT_EN adds the counters full_stall_cycles,
// wakeups and issues (cleared only by reset, read hierarchically).
module rs_cdb_wakeup #(
  parameter int RS_ENTRIES = core_pkg::RS_ENTRIES_DEFAULT,
  parameter int CDB_PORTS  = 2,
  parameter int XLEN       = core_pkg::XLEN,
  parameter int PHYS_W     = core_pkg::LOG2_PREGS,
  parameter int ROB_W      = 6,
  parameter int OP_W       = 6,
  localparam int OCC_W     = $clog2(RS_ENTRIES) + 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        disp_valid,
  output logic                        disp_ready,
  input  logic [OP_W-1:0]             disp_op,
  input  logic [ROB_W-1:0]            disp_rob_tag,
  input  logic [PHYS_W-1:0]           disp_dst_tag,
  input  logic [PHYS_W-1:0]           disp_src1_tag,
  input  logic                        disp_src1_ready,
  input  logic [XLEN-1:0]             disp_src1_value,
  input  logic [PHYS_W-1:0]           disp_src2_tag,
  input  logic                        disp_src2_ready,
  input  logic [XLEN-1:0]             disp_src2_value,
  input  logic [CDB_PORTS-1:0]        cdb_valid,
  input  logic [CDB_PORTS*PHYS_W-1:0] cdb_tag,
  input  logic [CDB_PORTS*XLEN-1:0]   cdb_value,
  input  logic [CDB_PORTS*ROB_W-1:0]  cdb_rob_tag,
  output logic                        issue_valid,
  input  logic                        issue_ready,
  output logic [OP_W-1:0]             issue_op,
  output logic [ROB_W-1:0]            issue_rob_tag,
  output logic [PHYS_W-1:0]           issue_dst_tag,
  output logic [XLEN-1:0]             issue_src1_value,
  output logic [XLEN-1:0]             issue_src2_value,
  output logic [OCC_W-1:0]            occupancy
);

  import core_pkg::*;

  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(RS_ENTRIES);

  // Returns {hit, value}; scanning high to low lets the lowest matching port win.
  function automatic logic [XLEN:0] cdb_lookup(
    input logic [PHYS_W-1:0]           tag,
    input logic [CDB_PORTS-1:0]        vld,
    input logic [CDB_PORTS*PHYS_W-1:0] tags,
    input logic [CDB_PORTS*XLEN-1:0]   vals
  );
    logic [XLEN:0] hit;
    hit = '0;
    for (int p = CDB_PORTS - 1; p >= 0; p--) begin
      if (vld[p] && (tags[p*PHYS_W +: PHYS_W] == tag)) begin
        hit = {1'b1, vals[p*XLEN +: XLEN]};
      end
    end
    return hit;
  endfunction

  rs_entry_t entry_q [RS_ENTRIES];
  rs_entry_t entry_d [RS_ENTRIES];

  logic [XLEN:0] s1_hit [RS_ENTRIES];
  logic [XLEN:0] s2_hit [RS_ENTRIES];
  logic [XLEN:0] byp1_hit;
  logic [XLEN:0] byp2_hit;

  logic [RS_ENTRIES-1:0] valid_vec;
  logic [RS_ENTRIES-1:0] req_vec;
  logic [RS_ENTRIES-1:0] gnt;
  logic [RS_ENTRIES-1:0] free_slot_oh;
  logic [RS_ENTRIES-1:0] alloc_fire;
  logic [RS_ENTRIES-1:0] free_fire;
  logic [RS_ENTRIES-1:0] cap1_vec;
  logic [RS_ENTRIES-1:0] cap2_vec;

  logic [OCC_W-1:0] occ_q, occ_d;
  logic             disp_fire;
  logic             sel_fire;

  logic [OP_W-1:0]   sel_op;
  logic [ROB_W-1:0]  sel_rob;
  logic [PHYS_W-1:0] sel_dst;
  logic [XLEN-1:0]   sel_v1, sel_v2;

  logic              issue_valid_q;
  logic [OP_W-1:0]   issue_op_q;
  logic [ROB_W-1:0]  issue_rob_q;
  logic [PHYS_W-1:0] issue_dst_q;
  logic [XLEN-1:0]   issue_v1_q, issue_v2_q;

  // ROB tags on the CDB are consumed by the ROB, not by this station.
  logic unused_cdb_rob;
  assign unused_cdb_rob = ^cdb_rob_tag;

  // Per-entry CDB compare network and ready vector.
  genvar gi;
  generate
    for (gi = 0; gi < RS_ENTRIES; gi++) begin : g_cmp
      assign s1_hit[gi]    = cdb_lookup(entry_q[gi].src1_tag, cdb_valid, cdb_tag, cdb_value);
      assign s2_hit[gi]    = cdb_lookup(entry_q[gi].src2_tag, cdb_valid, cdb_tag, cdb_value);
      assign valid_vec[gi] = entry_q[gi].valid;
      assign req_vec[gi]   = entry_q[gi].valid & entry_q[gi].src1_ready & entry_q[gi].src2_ready;
    end
  endgenerate

  assign byp1_hit = cdb_lookup(disp_src1_tag, cdb_valid, cdb_tag, cdb_value);
  assign byp2_hit = cdb_lookup(disp_src2_tag, cdb_valid, cdb_tag, cdb_value);

  // Readiness is from registered occupancy only, so a same-cycle issue never
  // makes room for a same-cycle dispatch.
  assign disp_ready = (occ_q < OCC_FULL);
  assign disp_fire  = disp_valid & disp_ready & ~flush;
  assign sel_fire   = (~issue_valid_q | issue_ready) & (|req_vec) & ~flush;
  assign alloc_fire = disp_fire ? free_slot_oh : '0;
  assign free_fire  = sel_fire ? gnt : '0;

  // Lowest-index free slot as a one-hot vector.
  always_comb begin
    free_slot_oh = '0;
    for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_vec[i]) begin
        free_slot_oh    = '0;
        free_slot_oh[i] = 1'b1;
      end
    end
  end

  rs_age_matrix #(.N(RS_ENTRIES)) u_age (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .alloc_i (alloc_fire),
    .free_i  (free_fire),
    .req_i   (req_vec),
    .gnt_o   (gnt)
  );

  // One-hot mux of the granted entry's payload.
  always_comb begin
    sel_op  = '0;
    sel_rob = '0;
    sel_dst = '0;
    sel_v1  = '0;
    sel_v2  = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      if (gnt[i]) begin
        sel_op  = entry_q[i].op;
        sel_rob = entry_q[i].rob_tag;
        sel_dst = entry_q[i].dst_tag;
        sel_v1  = entry_q[i].src1_value;
        sel_v2  = entry_q[i].src2_value;
      end
    end
  end

  // Entry next state: wakeup capture, free on select, allocate with bypass, flush.
  always_comb begin
    cap1_vec = '0;
    cap2_vec = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      entry_d[i] = entry_q[i];
      if (entry_q[i].valid) begin
        if (!entry_q[i].src1_ready && s1_hit[i][XLEN]) begin
          entry_d[i].src1_ready = 1'b1;
          entry_d[i].src1_value = s1_hit[i][XLEN-1:0];
          cap1_vec[i]           = 1'b1;
        end
        if (!entry_q[i].src2_ready && s2_hit[i][XLEN]) begin
          entry_d[i].src2_ready = 1'b1;
          entry_d[i].src2_value = s2_hit[i][XLEN-1:0];
          cap2_vec[i]           = 1'b1;
        end
        if (free_fire[i]) begin
          entry_d[i].valid = 1'b0;
        end
      end else if (alloc_fire[i]) begin
        entry_d[i].valid      = 1'b1;
        entry_d[i].op         = disp_op;
        entry_d[i].rob_tag    = disp_rob_tag;
        entry_d[i].dst_tag    = disp_dst_tag;
        entry_d[i].src1_tag   = disp_src1_tag;
        entry_d[i].src2_tag   = disp_src2_tag;
        entry_d[i].src1_ready = disp_src1_ready | byp1_hit[XLEN];
        entry_d[i].src2_ready = disp_src2_ready | byp2_hit[XLEN];
        entry_d[i].src1_value = disp_src1_ready ? disp_src1_value : byp1_hit[XLEN-1:0];
        entry_d[i].src2_value = disp_src2_ready ? disp_src2_value : byp2_hit[XLEN-1:0];
        cap1_vec[i]           = ~disp_src1_ready & byp1_hit[XLEN];
        cap2_vec[i]           = ~disp_src2_ready & byp2_hit[XLEN];
      end
      if (flush) begin
        entry_d[i].valid = 1'b0;
        cap1_vec[i]      = 1'b0;
        cap2_vec[i]      = 1'b0;
      end
    end
  end

  // Entry storage register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RS_ENTRIES; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < RS_ENTRIES; i++) begin
        entry_q[i] <= entry_d[i];
      end
    end
  end

  // Occupancy: +1 dispatch, -1 select, cleared by flush.
  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (disp_fire && !sel_fire) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!disp_fire && sel_fire) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) occ_q <= '0;
    else       occ_q <= occ_d;
  end

  // Issue register: load on select, hold while stalled, empty when consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_valid_q <= 1'b0;
      issue_op_q    <= '0;
      issue_rob_q   <= '0;
      issue_dst_q   <= '0;
      issue_v1_q    <= '0;
      issue_v2_q    <= '0;
    end else if (flush) begin
      issue_valid_q <= 1'b0;
    end else if (sel_fire) begin
      issue_valid_q <= 1'b1;
      issue_op_q    <= sel_op;
      issue_rob_q   <= sel_rob;
      issue_dst_q   <= sel_dst;
      issue_v1_q    <= sel_v1;
      issue_v2_q    <= sel_v2;
    end else if (issue_ready) begin
      issue_valid_q <= 1'b0;
    end
  end

  assign issue_valid      = issue_valid_q;
  assign issue_op         = issue_op_q;
  assign issue_rob_tag    = issue_rob_q;
  assign issue_dst_tag    = issue_dst_q;
  assign issue_src1_value = issue_v1_q;
  assign issue_src2_value = issue_v2_q;
  assign occupancy        = occ_q;

`ifdef RS_PERF_CNT_EN
  logic [31:0] full_stall_cycles;
  logic [31:0] wakeups;
  logic [31:0] issues;

  // Performance counters; only reset clears them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_stall_cycles <= '0;
      wakeups           <= '0;
      issues            <= '0;
    end else begin
      if (disp_valid && !disp_ready) full_stall_cycles <= full_stall_cycles + 32'd1;
      wakeups <= wakeups + 32'($countones(cap1_vec)) + 32'($countones(cap2_vec));
      if (sel_fire) issues <= issues + 32'd1;
    end
  end
`else
`endif

endmodule

// File: tb/tb_rs_cdb_wakeup.sv
// Self-checking bench for rs_cdb_wakeup: a vector table of single-op
// dispatches (ready, bypass, port priority) plus hand-written sequences for
// wakeup, full station, age ordering, stall, flush and asynchronous reset.
module tb_rs_cdb_wakeup;

  localparam int XLEN = 32, PHYS_W = 6, ROB_W = 6, OP_W = 6, CDB_PORTS = 2;

  logic                        clk = 1'b0;
  logic                        reset, flush;
  logic                        disp_valid, disp_ready;
  logic [OP_W-1:0]             disp_op;
  logic [ROB_W-1:0]            disp_rob_tag;
  logic [PHYS_W-1:0]           disp_dst_tag, disp_src1_tag, disp_src2_tag;
  logic                        disp_src1_ready, disp_src2_ready;
  logic [XLEN-1:0]             disp_src1_value, disp_src2_value;
  logic [CDB_PORTS-1:0]        cdb_valid;
  logic [CDB_PORTS*PHYS_W-1:0] cdb_tag;
  logic [CDB_PORTS*XLEN-1:0]   cdb_value;
  logic [CDB_PORTS*ROB_W-1:0]  cdb_rob_tag;
  logic                        issue_valid, issue_ready;
  logic [OP_W-1:0]             issue_op;
  logic [ROB_W-1:0]            issue_rob_tag;
  logic [PHYS_W-1:0]           issue_dst_tag;
  logic [XLEN-1:0]             issue_src1_value, issue_src2_value;
  logic [3:0]                  occupancy;

  always #5 clk = ~clk;

  rs_cdb_wakeup dut (
    .clk(clk), .reset(reset), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_rob_tag(disp_rob_tag), .disp_dst_tag(disp_dst_tag),
    .disp_src1_tag(disp_src1_tag), .disp_src1_ready(disp_src1_ready), .disp_src1_value(disp_src1_value),
    .disp_src2_tag(disp_src2_tag), .disp_src2_ready(disp_src2_ready), .disp_src2_value(disp_src2_value),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .cdb_rob_tag(cdb_rob_tag),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_rob_tag(issue_rob_tag), .issue_dst_tag(issue_dst_tag),
    .issue_src1_value(issue_src1_value), .issue_src2_value(issue_src2_value),
    .occupancy(occupancy)
  );

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [ROB_W-1:0]  rob;
    logic [PHYS_W-1:0] dst;
    logic [XLEN-1:0]   s1;
    logic [XLEN-1:0]   s2;
  } issue_t;

  typedef struct {
    logic [OP_W-1:0]   op;
    logic [ROB_W-1:0]  rob;
    logic [PHYS_W-1:0] dst;
    logic [PHYS_W-1:0] t1;
    logic              r1;
    logic [XLEN-1:0]   v1;
    logic [PHYS_W-1:0] t2;
    logic              r2;
    logic [XLEN-1:0]   v2;
    logic [1:0]        cv;
    logic [PHYS_W-1:0] ct0;
    logic [XLEN-1:0]   cval0;
    logic [PHYS_W-1:0] ct1;
    logic [XLEN-1:0]   cval1;
    logic [XLEN-1:0]   e1;
    logic [XLEN-1:0]   e2;
  } vec_t;

  issue_t exp_q[$];
  int     checks = 0;
  int     fails  = 0;
  vec_t   vecs[7];

  function automatic issue_t mk_issue(input logic [5:0] op, input logic [5:0] rob, input logic [5:0] dst,
                                      input logic [31:0] s1, input logic [31:0] s2);
    issue_t r;
    r.op = op; r.rob = rob; r.dst = dst; r.s1 = s1; r.s2 = s2;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_valid = 1'b0;
    cdb_valid  = '0;
    flush      = 1'b0;
  endtask

  task automatic drive_disp(input logic [5:0] op, input logic [5:0] rob, input logic [5:0] dst,
                            input logic [5:0] t1, input logic r1, input logic [31:0] v1,
                            input logic [5:0] t2, input logic r2, input logic [31:0] v2);
    disp_valid = 1'b1;
    disp_op = op; disp_rob_tag = rob; disp_dst_tag = dst;
    disp_src1_tag = t1; disp_src1_ready = r1; disp_src1_value = v1;
    disp_src2_tag = t2; disp_src2_ready = r2; disp_src2_value = v2;
  endtask

  task automatic set_cdb(input logic [1:0] cv, input logic [5:0] t0, input logic [31:0] v0,
                         input logic [5:0] t1, input logic [31:0] v1);
    cdb_valid   = cv;
    cdb_tag     = {t1, t0};
    cdb_value   = {v1, v0};
    cdb_rob_tag = 12'($urandom);
  endtask

  // Scoreboard: every accepted issue handshake is compared with the queue head.
  always @(negedge clk) begin
    if (!reset && issue_valid && issue_ready) begin
      issue_t got, want;
      got = {issue_op, issue_rob_tag, issue_dst_tag, issue_src1_value, issue_src2_value};
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL issue_unexpected: got rob=%0d op=%0d, required no issue", issue_rob_tag, issue_op);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          fails++;
          $display("FAIL issue_fields: got op=%0h rob=%0h dst=%0h s1=%h s2=%h, required op=%0h rob=%0h dst=%0h s1=%h s2=%h",
                   got.op, got.rob, got.dst, got.s1, got.s2, want.op, want.rob, want.dst, want.s1, want.s2);
        end else begin
          $display("issue rob=%0d op=%0d dst=%0d s1=%h s2=%h", got.rob, got.op, got.dst, got.s1, got.s2);
        end
      end
    end
  end

  initial begin
    vecs[0] = '{6'd1,  6'd1,  6'd3,  6'd1,  1'b1, 32'h1111_1111, 6'd2,  1'b1, 32'h2222_2222,
                2'b00, 6'd0, 32'h0, 6'd0, 32'h0, 32'h1111_1111, 32'h2222_2222};
    vecs[1] = '{6'd2,  6'd2,  6'd4,  6'd3,  1'b1, 32'hAAAA_5555, 6'd4,  1'b1, 32'h0,
                2'b00, 6'd0, 32'h0, 6'd0, 32'h0, 32'hAAAA_5555, 32'h0};
    vecs[2] = '{6'd3,  6'd3,  6'd5,  6'd6,  1'b1, 32'h1234,      6'd5,  1'b0, 32'h0,
                2'b01, 6'd5, 32'h77, 6'd0, 32'h0, 32'h1234, 32'h77};
    vecs[3] = '{6'd4,  6'd4,  6'd6,  6'd9,  1'b0, 32'h0,         6'd10, 1'b1, 32'h3,
                2'b11, 6'd9, 32'h1, 6'd9, 32'h2, 32'h1, 32'h3};
    vecs[4] = '{6'd5,  6'd5,  6'd7,  6'd7,  1'b0, 32'h0,         6'd8,  1'b0, 32'h0,
                2'b11, 6'd8, 32'h88, 6'd7, 32'h70, 32'h70, 32'h88};
    vecs[5] = '{6'd6,  6'd6,  6'd8,  6'd20, 1'b1, 32'h1,         6'd21, 1'b1, 32'h2,
                2'b01, 6'd20, 32'h999, 6'd0, 32'h0, 32'h1, 32'h2};
    vecs[6] = '{6'h3F, 6'h3F, 6'h3F, 6'd30, 1'b1, 32'hFFFF_FFFF, 6'd31, 1'b1, 32'hFFFF_FFFF,
                2'b00, 6'd0, 32'h0, 6'd0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

    reset = 1'b1; issue_ready = 1'b1;
    idle();
    drive_disp(0, 0, 0, 0, 0, 0, 0, 0, 0);
    disp_valid = 1'b0;
    set_cdb(2'b00, 0, 0, 0, 0);
    cyc(); cyc();
    check("rst_issue_valid", issue_valid, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_disp_ready", disp_ready, 1);
    check("rst_issue_op", issue_op, 0);
    check("rst_issue_src1", issue_src1_value, 0);
    check("rst_issue_src2", issue_src2_value, 0);
    reset = 1'b0;
    cyc();

    // Vector table: one op each, checking latency and drain.
    for (int k = 0; k < 7; k++) begin
      drive_disp(vecs[k].op, vecs[k].rob, vecs[k].dst, vecs[k].t1, vecs[k].r1, vecs[k].v1,
                 vecs[k].t2, vecs[k].r2, vecs[k].v2);
      set_cdb(vecs[k].cv, vecs[k].ct0, vecs[k].cval0, vecs[k].ct1, vecs[k].cval1);
      exp_q.push_back(mk_issue(vecs[k].op, vecs[k].rob, vecs[k].dst, vecs[k].e1, vecs[k].e2));
      cyc(); idle();
      check($sformatf("v%0d_valid_e0", k), issue_valid, 0);
      check($sformatf("v%0d_occ_e0", k), occupancy, 1);
      cyc();
      check($sformatf("v%0d_valid_e1", k), issue_valid, 1);
      cyc();
      check($sformatf("v%0d_valid_e2", k), issue_valid, 0);
      check($sformatf("v%0d_occ_e2", k), occupancy, 0);
    end

    // CDB wakeup of a waiting source on port 1.
    drive_disp(10, 10, 10, 12, 0, 0, 13, 1, 32'h5);
    cyc(); idle();
    check("wk_valid_wait", issue_valid, 0);
    check("wk_occ", occupancy, 1);
    set_cdb(2'b10, 12, 32'hBAD, 33, 32'hBAD);
    cyc(); idle(); cyc();
    check("wk_no_false_wake", issue_valid, 0);
    set_cdb(2'b10, 0, 0, 12, 32'hDEAD);
    exp_q.push_back(mk_issue(10, 10, 10, 32'hDEAD, 32'h5));
    cyc(); idle();
    check("wk_valid_e0", issue_valid, 0);
    cyc();
    check("wk_valid_e1", issue_valid, 1);
    cyc();
    check("wk_drained", occupancy, 0);

    // Fill the station with waiting ops; entries land in index order.
    for (int k = 0; k < 8; k++) begin
      drive_disp(6'(32 + k), 6'(32 + k), 6'(k), 6'(20 + k), 1'b0, 32'h0, 6'(50 + k), 1'b1, 32'(k));
      cyc();
    end
    check("full_occ", occupancy, 8);
    check("full_disp_ready", disp_ready, 0);
    drive_disp(62, 62, 62, 0, 1, 0, 0, 1, 0);
    cyc(); idle();
    check("full_drop_occ", occupancy, 8);

    // Wake entry 6 and older entry 2 together: entry 2 first.
    set_cdb(2'b11, 26, 32'h66, 22, 32'h22);
    exp_q.push_back(mk_issue(34, 34, 2, 32'h22, 32'h2));
    exp_q.push_back(mk_issue(38, 38, 6, 32'h66, 32'h6));
    cyc(); idle();
    check("age_valid_e0", issue_valid, 0);
    cyc();
    check("age_valid_e1", issue_valid, 1);
    check("age_first_rob", issue_rob_tag, 34);
    check("age_freed_occ", occupancy, 7);
    check("age_freed_ready", disp_ready, 1);
    cyc();
    check("age_second_occ", occupancy, 6);
    // New op reuses slot 2 but is younger than entry 7.
    drive_disp(50, 50, 9, 40, 0, 0, 41, 1, 32'h50);
    cyc(); idle();
    check("age_realloc_occ", occupancy, 7);
    set_cdb(2'b11, 40, 32'h4040, 27, 32'h7777);
    exp_q.push_back(mk_issue(39, 39, 7, 32'h7777, 32'h7));
    exp_q.push_back(mk_issue(50, 50, 9, 32'h4040, 32'h50));
    cyc(); idle(); cyc();
    check("age_old7_rob", issue_rob_tag, 39);
    cyc(); cyc();
    check("age_drain_valid", issue_valid, 0);
    check("age_drain_occ", occupancy, 5);

    // Both ports carry the waiting tag: the lower port's value is captured.
    set_cdb(2'b11, 20, 32'h1, 20, 32'h2);
    exp_q.push_back(mk_issue(32, 32, 0, 32'h1, 32'h0));
    cyc(); idle(); cyc();
    check("prio_valid", issue_valid, 1);
    cyc();
    check("prio_occ", occupancy, 4);

    // Stall: issue fields held while issue_ready is low.
    issue_ready = 1'b0;
    set_cdb(2'b01, 21, 32'h2121, 0, 0);
    cyc(); idle(); cyc();
    for (int k = 0; k < 3; k++) begin
      if (k == 0) set_cdb(2'b01, 23, 32'h2323, 0, 0);
      cyc(); idle();
      check($sformatf("stall%0d_valid", k), issue_valid, 1);
      check($sformatf("stall%0d_rob", k), issue_rob_tag, 33);
      check($sformatf("stall%0d_src1", k), issue_src1_value, 32'h2121);
      check($sformatf("stall%0d_src2", k), issue_src2_value, 32'h1);
    end

    // Flush with a dispatch in the same cycle: everything dropped.
    flush = 1'b1;
    drive_disp(60, 60, 60, 0, 1, 32'h60, 0, 1, 32'h61);
    cyc(); idle();
    check("flush_occ", occupancy, 0);
    check("flush_valid", issue_valid, 0);
    check("flush_disp_ready", disp_ready, 1);
    issue_ready = 1'b1;
    cyc(); cyc(); cyc();
    check("flush_nothing_issues", issue_valid, 0);
    check("flush_occ_after", occupancy, 0);

    // Asynchronous reset mid-operation.
    drive_disp(61, 61, 1, 0, 1, 32'hA, 0, 1, 32'hB);
    cyc(); idle();
    #2 reset = 1'b1;
    #1;
    check("areset_occ", occupancy, 0);
    check("areset_valid", issue_valid, 0);
    cyc();
    reset = 1'b0;
    cyc(); cyc();
    check("areset_no_issue", issue_valid, 0);
    check("areset_occ_after", occupancy, 0);

    for (int k = 0; k < 20; k++) begin
      if (exp_q.size() == 0) break;
      cyc();
    end
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
